// File: rtl/square_plotter_if.sv
// square_plotter_if: draw-request inputs and pixel-write outputs of the square plotter
interface square_plotter_if;
    logic       start;
    logic [1:0] size_sel;
    logic [8:0] x0;
    logic [7:0] y0;
    logic [2:0] colour_in;
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;
    modport master (
        output start, size_sel, x0, y0, colour_in,
        input  x_out, y_out, colour_out, plot, busy, done
    );
    modport slave (
        input  start, size_sel, x0, y0, colour_in,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/square_plotter.sv
// square_plotter: draws a filled SxS square one pixel per clock into a 320x240 VGA frame buffer
module square_plotter (
    input  logic            clock,
    input  logic            resetn,
    square_plotter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
    state_t     state, state_nxt;
    logic [8:0] xl, xl_nxt, x_reg, x_nxt;
    logic [7:0] yl, yl_nxt, y_reg, y_nxt;
    logic [2:0] colour, colour_nxt;
    logic [4:0] smax, smax_nxt, dx, dx_nxt, dy, dy_nxt;
    logic       plot_reg, plot_nxt, wrap, last;
    logic [9:0] xs;
    logic [8:0] ys;
    // next state, scan counters and the registered pixel presented during the coming cycle
    always_comb begin
        state_nxt  = state;
        xl_nxt     = xl;
        yl_nxt     = yl;
        colour_nxt = colour;
        smax_nxt   = smax;
        dx_nxt     = dx;
        dy_nxt     = dy;
        x_nxt      = x_reg;
        y_nxt      = y_reg;
        plot_nxt   = 1'b0;
        wrap       = dx == smax;
        last       = wrap && dy == smax;
        case (state)
            IDLE: if (bus.start && bus.size_sel != 2'd3) begin
                state_nxt  = DRAW;
                xl_nxt     = bus.x0;
                yl_nxt     = bus.y0;
                colour_nxt = bus.colour_in;
                smax_nxt   = (bus.size_sel == 2'd0) ? 5'd3 : (bus.size_sel == 2'd1) ? 5'd9 : 5'd19;
                dx_nxt     = 5'd0;
                dy_nxt     = 5'd0;
            end
            DRAW: if (last) state_nxt = DONE;
                  else begin
                      dx_nxt = wrap ? 5'd0 : dx + 5'd1;
                      dy_nxt = wrap ? dy + 5'd1 : dy;
                  end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        xs = {1'b0, xl_nxt} + {5'b0, dx_nxt};
        ys = {1'b0, yl_nxt} + {4'b0, dy_nxt};
        if (state_nxt == DRAW) begin
            x_nxt    = xs[8:0];
            y_nxt    = ys[7:0];
            plot_nxt = (xs < 10'd320) && (ys < 9'd240);
        end
    end
    // state and datapath registers, cleared asynchronously so a reset aborts a draw at once
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            xl       <= '0;
            yl       <= '0;
            colour   <= '0;
            smax     <= '0;
            dx       <= '0;
            dy       <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            plot_reg <= 1'b0;
        end else begin
            state    <= state_nxt;
            xl       <= xl_nxt;
            yl       <= yl_nxt;
            colour   <= colour_nxt;
            smax     <= smax_nxt;
            dx       <= dx_nxt;
            dy       <= dy_nxt;
            x_reg    <= x_nxt;
            y_reg    <= y_nxt;
            plot_reg <= plot_nxt;
        end
    end
    assign bus.x_out      = x_reg;
    assign bus.y_out      = y_reg;
    assign bus.colour_out = colour;
    assign bus.plot       = plot_reg;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
endmodule

// File: tb/tb_square_plotter.sv
// tb_square_plotter: directed scenarios for the square plotter with hand-derived pixel sequences
module tb_square_plotter;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    square_plotter_if bus();
    square_plotter dut (.clock(clock), .resetn(resetn), .bus(bus.slave));
    always #10 clock = ~clock;
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    task automatic launch(input logic [1:0] sz, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c, input logic hold);
        @(negedge clock);
        bus.size_sel  = sz;
        bus.x0        = x;
        bus.y0        = y;
        bus.colour_in = c;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start = hold;
    endtask
    task automatic test_reset();
        logic [22:0] got;
        bus.start = 1'b0;
        bus.size_sel = 2'd0;
        bus.x0 = 9'd0;
        bus.y0 = 8'd0;
        bus.colour_in = 3'd0;
        resetn = 1'b0;
        #5;
        got = {bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
        checks++;
        if (got !== 23'd0) begin errors++; $display("FAIL reset_async got %h exp %h", got, 23'd0); end
        repeat (2) @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        got = {bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
        checks++;
        if (got !== 23'd0) begin errors++; $display("FAIL reset_held got %h exp %h", got, 23'd0); end
        bus.start = 1'b0;
        resetn = 1'b1;
    endtask
    task automatic test_square(input logic [1:0] sz, input logic [8:0] x0, input logic [7:0] y0, input logic [2:0] c, input int exp_plots, input string name);
        int s, ix, iy, plots;
        logic ep;
        logic [22:0] got, exp;
        s = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 10 : 20;
        plots = 0;
        launch(sz, x0, y0, c, 1'b0);
        for (int k = 0; k < s * s; k++) begin
            @(negedge clock);
            ix = int'(x0) + k % s;
            iy = int'(y0) + k / s;
            ep = ix < 320 && iy < 240;
            exp = {ep, 2'b10, ix[8:0], iy[7:0], c};
            got = {bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
            if (bus.plot === 1'b1) plots++;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL %s pixel %0d got %h exp %h", name, k, got, exp); end
        end
        ix = int'(x0) + s - 1;
        iy = int'(y0) + s - 1;
        @(negedge clock);
        exp = {3'b011, ix[8:0], iy[7:0], c};
        got = {bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL %s done_cycle got %h exp %h", name, got, exp); end
        @(negedge clock);
        exp = {3'b000, ix[8:0], iy[7:0], c};
        got = {bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL %s idle_hold got %h exp %h", name, got, exp); end
        checks++;
        if (plots !== exp_plots) begin errors++; $display("FAIL %s plot_count got %0d exp %0d", name, plots, exp_plots); end
    endtask
    task automatic test_start_ignored();
        int ix, iy;
        logic seen;
        logic [22:0] got, exp;
        launch(2'd1, 9'd100, 8'd50, 3'd6, 1'b1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            ix = 100 + k % 10;
            iy = 50 + k / 10;
            exp = {3'b110, ix[8:0], iy[7:0], 3'd6};
            got = {bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL ignore pixel %0d got %h exp %h", k, got, exp); end
            if (k == 29) begin
                bus.x0 = 9'd200;
                bus.size_sel = 2'd0;
                bus.colour_in = 3'd1;
            end
        end
        @(negedge clock);
        exp = {3'b011, 9'd109, 8'd59, 3'd6};
        got = {bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL ignore done_cycle got %h exp %h", got, exp); end
        @(negedge clock);
        exp = {3'b000, 9'd109, 8'd59, 3'd6};
        got = {bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL ignore idle_after_done got %h exp %h", got, exp); end
        @(negedge clock);
        exp = {3'b110, 9'd200, 8'd50, 3'd1};
        got = {bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL ignore new_accept got %h exp %h", got, exp); end
        bus.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            seen = bus.done;
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL ignore second_done got %b exp 1", seen); end
        @(negedge clock);
    endtask
    task automatic test_reserved();
        @(negedge clock);
        bus.size_sel = 2'd3;
        bus.x0 = 9'd7;
        bus.start = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if ({bus.busy, bus.plot} !== 2'b00) begin errors++; $display("FAIL reserved busy_plot got %b exp 00", {bus.busy, bus.plot}); end
        end
        bus.start = 1'b0;
    endtask
    task automatic test_reset_mid();
        logic [22:0] got;
        int dones, busys;
        launch(2'd0, 9'd10, 8'd20, 3'b101, 1'b0);
        repeat (7) @(negedge clock);
        checks++;
        if ({bus.plot, bus.x_out, bus.y_out} !== {1'b1, 9'd12, 8'd21}) begin
            errors++; $display("FAIL midreset pixel7 got %b %0d %0d exp 1 12 21", bus.plot, bus.x_out, bus.y_out);
        end
        #2;
        resetn = 1'b0;
        #1;
        got = {bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
        checks++;
        if (got !== 23'd0) begin errors++; $display("FAIL midreset async_clear got %h exp %h", got, 23'd0); end
        #2;
        resetn = 1'b1;
        dones = 0;
        busys = 0;
        repeat (20) begin
            @(negedge clock);
            dones += int'(bus.done);
            busys += int'(bus.busy);
        end
        checks++;
        if (dones !== 0 || busys !== 0) begin errors++; $display("FAIL midreset no_done got done=%0d busy=%0d exp 0 0", dones, busys); end
        test_square(2'd0, 9'd10, 8'd20, 3'b101, 16, "after_reset");
    endtask
    initial begin
        test_reset();
        test_square(2'd0, 9'd10, 8'd20, 3'b101, 16, "small");
        test_square(2'd2, 9'd0, 8'd0, 3'b010, 400, "big");
        test_square(2'd1, 9'd315, 8'd235, 3'b001, 25, "clip");
        test_start_ignored();
        test_reserved();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/square_plotter.md
SQUARE_PLOTTER -- requirements
Module: square_plotter

Interface
REQ-001 The block SHALL have exactly one clock domain and a reset that is asynchronous and active-low.
REQ-002 clock  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset; low forces reset state immediately, independent of clock.
REQ-004 start  input  1  draw request; sampled only in IDLE.
REQ-005 size_sel  input  2  square size: 0 = 4x4, 1 = 10x10, 2 = 20x20, 3 = reserved.
REQ-006 x0  input  9  screen column of the square's top-left pixel.
REQ-007 y0  input  8  screen row of the square's top-left pixel.
REQ-008 colour_in  input  3  fill colour.
REQ-009 x_out  output  9  column of the current pixel, x0 + dx.
REQ-010 y_out  output  8  row of the current pixel, y0 + dy.
REQ-011 colour_out  output  3  latched fill colour.
REQ-012 plot  output  1  write strobe to the VGA adapter; high means write colour_out at (x_out, y_out) this cycle.
REQ-013 busy  output  1  high in DRAW and DONE.
REQ-014 done  output  1  single-cycle completion pulse.

Function
REQ-015 The FSM SHALL have three states: IDLE, DRAW, DONE.
REQ-016 IDLE transitions:
- start=1 and size_sel != 3: latch x0, y0, colour_in and size; clear dx and dy to 0; next state DRAW.
- start=1 and size_sel = 3: no action; remain in IDLE.
REQ-017 While DRAW is active, start and all data inputs SHALL be ignored; the latched values SHALL be used.
REQ-018 Each DRAW cycle SHALL present one pixel, in this order:
- dx advances first, from 0 to S-1, where S = 4, 10 or 20.
- When dx = S-1, dx wraps to 0 and dy increments.
REQ-019 Pixel (dx=S-1, dy=S-1) SHALL be the last pixel; next state DONE.
REQ-020 DONE SHALL last exactly one cycle, with done=1 and plot=0; next state IDLE.
REQ-021 A start asserted during DONE SHALL be ignored.
REQ-022 Latency: if start is accepted at edge N, plot SHALL be high for cycles N+1 through N+S*S, and done SHALL be high at cycle N+S*S+1.
REQ-023 Coordinate arithmetic:
- dx and dy are 5-bit counters.
- x0+dx is computed at 10 bits and y0+dy at 9 bits.
- x_out and y_out are the low 9 and 8 bits of those sums.
REQ-024 Clipping: a pixel with x0+dx >= 320 or y0+dy >= 240 SHALL have plot=0, but SHALL still take one cycle, so the total draw time stays S*S cycles.
REQ-025 In IDLE:
- plot=0, busy=0, done=0.
- x_out, y_out and colour_out hold their last values.
REQ-026 Output timing: plot, busy, done, x_out, y_out and colour_out SHALL be registered or decoded directly from registered state, with no combinational path from any input.

Reset
REQ-027 When resetn=0, the block SHALL asynchronously force:
- state = IDLE; dx = dy = 0;
- x_out = 0, y_out = 0, colour_out = 0;
- plot = 0, busy = 0, done = 0.
REQ-028 A reset asserted mid-DRAW SHALL abort the square with no done pulse; the first start after resetn returns high SHALL behave per REQ-016.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Small square: start with size_sel=0, x0=10, y0=20, colour_in=3'b101 -> 16 plot cycles, pixel order (10,20),(11,20),(12,20),(13,20),(10,21)... ending at (13,23); done one cycle later; busy high for 17 cycles.
- Big square: size_sel=2, x0=0, y0=0 -> 400 plot cycles; last pixel (19,19); done at cycle 401 after the accepting edge.
- Clipping: size_sel=1, x0=315, y0=235 -> 100 DRAW cycles, of which exactly 25 have plot=1 (x 315..319, y 235..239); done at cycle 101.
- Start ignored: start held high throughout a size_sel=1 draw, with x0 changed mid-draw -> exactly one 100-pixel square at the original x0; the DONE cycle ignores start; a new draw is accepted in the following IDLE cycle. Separately, start with size_sel=3 -> busy stays 0.
- Reset mid-draw: resetn=0 asynchronously at pixel 7 of a size_sel=0 draw -> plot, busy and done go 0 without waiting for a clock edge, with no done pulse; the next start draws a full 16 pixels from dx=dy=0.
